// File: rtl/ahb_arbiter_m2s_if.sv
// Arbitration bundle between the three bus masters and the central AHB arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' view.
interface ahb_arbiter_m2s_if;
    logic       in_HBUSREQ_CPU;
    logic       in_HBUSREQ_Accelerator;
    logic       in_HBUSREQ_Debug;
    logic       in_HLOCK_CPU;
    logic       in_HLOCK_Accelerator;
    logic       in_HLOCK_Debug;
    logic [1:0] in_HTRANS;
    logic       in_HREADY;
    logic       out_HGRANT_CPU;
    logic       out_HGRANT_Accelerator;
    logic       out_HGRANT_Debug;
    logic [1:0] out_HMASTER;
    logic [1:0] out_HMASTER_data;
    logic       out_HMASTLOCK;

    modport slave (
        input  in_HBUSREQ_CPU, in_HBUSREQ_Accelerator, in_HBUSREQ_Debug,
        input  in_HLOCK_CPU, in_HLOCK_Accelerator, in_HLOCK_Debug,
        input  in_HTRANS, in_HREADY,
        output out_HGRANT_CPU, out_HGRANT_Accelerator, out_HGRANT_Debug,
        output out_HMASTER, out_HMASTER_data, out_HMASTLOCK
    );

    modport master (
        output in_HBUSREQ_CPU, in_HBUSREQ_Accelerator, in_HBUSREQ_Debug,
        output in_HLOCK_CPU, in_HLOCK_Accelerator, in_HLOCK_Debug,
        output in_HTRANS, in_HREADY,
        input  out_HGRANT_CPU, out_HGRANT_Accelerator, out_HGRANT_Debug,
        input  out_HMASTER, out_HMASTER_data, out_HMASTLOCK
    );
endinterface

// File: rtl/ahb_arbiter_m2s.sv
// Three-master AHB arbiter: round-robin with bounded tenure, locked-sequence
// protection and parking on DEFAULT_MASTER. Grants and master indices are registered.
module ahb_arbiter_m2s #(
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_HOLD       = 16,
    parameter int HOLD_W         = 5
) (
    input logic              in_HCLK,
    input logic              in_HRESETn,
    ahb_arbiter_m2s_if.slave bus
);
    localparam int NUM_M = 3;

    localparam logic [1:0] ST_PARK    = 2'd0;
    localparam logic [1:0] ST_GRANTED = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [1:0]        DEF_IDX  = 2'(DEFAULT_MASTER);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [1:0]        HT_NSEQ  = 2'b10;

    function automatic logic [NUM_M-1:0] idx2oh(input logic [1:0] i);
        idx2oh = 3'b001 << i;
    endfunction

    function automatic logic [1:0] inc3(input logic [1:0] i);
        inc3 = (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    logic [1:0]        state, state_nxt;
    logic [NUM_M-1:0]  grant, grant_nxt;
    logic [HOLD_W-1:0] hold_cnt, cnt_nxt;
    logic [1:0]        hmaster, hmaster_data;
    logic              mastlock;

    logic [NUM_M-1:0]  req, lock;
    logic [1:0]        owner, cand1, cand2, win;
    logic              any_req, others_req, expired, xfer, arb_pt;

    assign req  = {bus.in_HBUSREQ_Debug, bus.in_HBUSREQ_Accelerator, bus.in_HBUSREQ_CPU};
    assign lock = {bus.in_HLOCK_Debug,   bus.in_HLOCK_Accelerator,   bus.in_HLOCK_CPU};

    // Current grant doubles as the round-robin pointer.
    always_comb begin
        owner = 2'd0;
        if (grant[1]) owner = 2'd1;
        if (grant[2]) owner = 2'd2;
    end

    assign cand1      = inc3(owner);
    assign cand2      = inc3(cand1);
    assign any_req    = |req;
    assign others_req = req[cand1] | req[cand2];
    // The owner sits last in the search, so an expired owner only wins when alone.
    assign win        = req[cand1] ? cand1 : (req[cand2] ? cand2 : owner);
    assign expired    = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX);
    assign xfer       = bus.in_HREADY & bus.in_HTRANS[1];
    assign arb_pt     = bus.in_HREADY & (state != ST_LOCKED);

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        cnt_nxt   = hold_cnt;
        case (state)
            ST_PARK: begin
                if (arb_pt && any_req) begin
                    state_nxt = ST_GRANTED;
                    grant_nxt = idx2oh(win);
                    cnt_nxt   = '0;
                end
            end
            ST_GRANTED: begin
                if (xfer && (hold_cnt != HOLD_MAX))
                    cnt_nxt = hold_cnt + 1'b1;
                if (arb_pt) begin
                    if (lock[owner] && (bus.in_HTRANS == HT_NSEQ)) begin
                        state_nxt = ST_LOCKED;
                        cnt_nxt   = hold_cnt;
                    end else if (!req[owner] || (expired && others_req)) begin
                        cnt_nxt = '0;
                        if (any_req) begin
                            grant_nxt = idx2oh(win);
                        end else begin
                            state_nxt = ST_PARK;
                            grant_nxt = idx2oh(DEF_IDX);
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (bus.in_HREADY && !lock[owner]) begin
                    state_nxt = ST_GRANTED;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_PARK;
                grant_nxt = idx2oh(DEF_IDX);
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge in_HCLK) begin
        if (!in_HRESETn) begin
            state        <= ST_PARK;
            grant        <= idx2oh(DEF_IDX);
            hold_cnt     <= '0;
            hmaster      <= DEF_IDX;
            hmaster_data <= DEF_IDX;
            mastlock     <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            hold_cnt <= cnt_nxt;
            // Address/data-phase indices advance only when the bus accepts a phase.
            if (bus.in_HREADY) begin
                hmaster      <= owner;
                hmaster_data <= hmaster;
                mastlock     <= (state == ST_LOCKED) || (state_nxt == ST_LOCKED);
            end
        end
    end

    assign bus.out_HGRANT_CPU         = grant[0];
    assign bus.out_HGRANT_Accelerator = grant[1];
    assign bus.out_HGRANT_Debug       = grant[2];
    assign bus.out_HMASTER            = hmaster;
    assign bus.out_HMASTER_data       = hmaster_data;
    assign bus.out_HMASTLOCK          = mastlock;
endmodule

// File: tb/tb_ahb_arbiter_m2s.sv
// Directed bench for ahb_arbiter_m2s with DEFAULT_MASTER=0, MAX_HOLD=4.
// Grant vectors are compared as {Debug, Accelerator, CPU}.
module tb_ahb_arbiter_m2s;
    logic in_HCLK = 1'b0;
    logic in_HRESETn;

    ahb_arbiter_m2s_if bus();

    ahb_arbiter_m2s #(
        .DEFAULT_MASTER(0),
        .MAX_HOLD(4),
        .HOLD_W(5)
    ) dut (
        .in_HCLK(in_HCLK),
        .in_HRESETn(in_HRESETn),
        .bus(bus)
    );

    always #5 in_HCLK = ~in_HCLK;

    localparam int GC = 1, GA = 2, GD = 4;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_HCLK);
        #1;
    endtask

    function automatic logic [31:0] gnt();
        return 32'({bus.out_HGRANT_Debug, bus.out_HGRANT_Accelerator, bus.out_HGRANT_CPU});
    endfunction

    task automatic set_req(input logic c, input logic a, input logic d);
        bus.in_HBUSREQ_CPU         = c;
        bus.in_HBUSREQ_Accelerator = a;
        bus.in_HBUSREQ_Debug       = d;
    endtask

    task automatic set_lock(input logic c, input logic a, input logic d);
        bus.in_HLOCK_CPU         = c;
        bus.in_HLOCK_Accelerator = a;
        bus.in_HLOCK_Debug       = d;
    endtask

    initial begin
        int eidx;
        int prev_idx;
        in_HRESETn    = 1'b0;
        set_req(0, 0, 0);
        set_lock(0, 0, 0);
        bus.in_HTRANS = 2'b00;
        bus.in_HREADY = 1'b1;

        // Reset held for two edges.
        tick();
        tick();
        chk("rst_grant", gnt(), GC);
        chk("rst_hmaster", 32'(bus.out_HMASTER), 0);
        chk("rst_hmaster_data", 32'(bus.out_HMASTER_data), 0);
        chk("rst_mastlock", 32'(bus.out_HMASTLOCK), 0);
        in_HRESETn = 1'b1;
        tick();
        chk("park_idle", gnt(), GC);

        // Accelerator alone: grant, then HMASTER, then HMASTER_data.
        set_req(0, 1, 0);
        tick();
        chk("acc_grant_e1", gnt(), GA);
        chk("acc_hmaster_e1", 32'(bus.out_HMASTER), 0);
        tick();
        chk("acc_hmaster_e2", 32'(bus.out_HMASTER), 1);
        chk("acc_hdata_e2", 32'(bus.out_HMASTER_data), 0);
        tick();
        chk("acc_hdata_e3", 32'(bus.out_HMASTER_data), 1);
        // Reset pulse between edges must not act asynchronously.
        #1 in_HRESETn = 1'b0;
        #1 chk("async_rst_grant", gnt(), GA);
        chk("async_rst_hmaster", 32'(bus.out_HMASTER), 1);
        in_HRESETn = 1'b1;
        tick();
        chk("acc_hold", gnt(), GA);
        set_req(0, 0, 0);
        tick();
        chk("repark_grant", gnt(), GC);
        tick();
        chk("repark_hmaster", 32'(bus.out_HMASTER), 0);

        // All request, continuous SEQ: tenure counts 4 transfers, handover on the next edge.
        set_req(1, 1, 1);
        bus.in_HTRANS = 2'b11;
        prev_idx = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            eidx = (k < 6) ? 1 : (k < 11) ? 2 : (k < 16) ? 0 : 1;
            chk($sformatf("rr_grant_%0d", k), gnt(), 32'(1 << eidx));
            chk($sformatf("rr_hmaster_%0d", k), 32'(bus.out_HMASTER), 32'(prev_idx));
            prev_idx = eidx;
        end

        // Locked sequence owned by Debug.
        set_req(0, 0, 0);
        bus.in_HTRANS = 2'b00;
        in_HRESETn = 1'b0;
        tick();
        in_HRESETn = 1'b1;
        set_req(0, 0, 1);
        tick();
        chk("dbg_grant", gnt(), GD);
        set_lock(0, 0, 1);
        bus.in_HTRANS = 2'b10;
        tick();
        chk("lock_enter_mastlock", 32'(bus.out_HMASTLOCK), 1);
        chk("lock_enter_grant", gnt(), GD);
        set_req(1, 0, 1);
        bus.in_HTRANS = 2'b11;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("lock_hold_grant_%0d", k), gnt(), GD);
            chk($sformatf("lock_hold_mastlock_%0d", k), 32'(bus.out_HMASTLOCK), 1);
        end
        chk("lock_hmaster", 32'(bus.out_HMASTER), 2);
        set_lock(0, 0, 0);
        set_req(1, 0, 0);
        tick();
        chk("lock_exit_grant", gnt(), GD);
        chk("lock_exit_mastlock", 32'(bus.out_HMASTLOCK), 1);
        tick();
        chk("post_lock_grant", gnt(), GC);
        chk("post_lock_mastlock", 32'(bus.out_HMASTLOCK), 0);
        tick();
        chk("post_lock_hmaster", 32'(bus.out_HMASTER), 0);
        chk("post_lock_hdata", 32'(bus.out_HMASTER_data), 2);
        tick();
        chk("post_lock_hdata2", 32'(bus.out_HMASTER_data), 0);

        // Pending handover stalled by three wait states.
        bus.in_HREADY = 1'b0;
        set_req(0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("wait_grant_%0d", k), gnt(), GC);
            chk($sformatf("wait_hmaster_%0d", k), 32'(bus.out_HMASTER), 0);
        end
        bus.in_HREADY = 1'b1;
        tick();
        chk("wait_release_grant", gnt(), GA);
        chk("wait_release_hmaster", 32'(bus.out_HMASTER), 0);

        // Reset while Accelerator holds a locked sequence.
        set_lock(0, 1, 0);
        bus.in_HTRANS = 2'b10;
        tick();
        chk("acc_lock_mastlock", 32'(bus.out_HMASTLOCK), 1);
        in_HRESETn = 1'b0;
        tick();
        chk("lockrst_grant", gnt(), GC);
        chk("lockrst_hmaster", 32'(bus.out_HMASTER), 0);
        chk("lockrst_hdata", 32'(bus.out_HMASTER_data), 0);
        chk("lockrst_mastlock", 32'(bus.out_HMASTLOCK), 0);
        // From PARK a locked NONSEQ request is only granted, not locked.
        in_HRESETn = 1'b1;
        tick();
        chk("lockrst_park_grant", gnt(), GA);
        chk("lockrst_park_mastlock", 32'(bus.out_HMASTLOCK), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ahb_arbiter_m2s.md
Name: ahb_arbiter_m2s

Overview:
- Central AHB bus arbiter sharing the single system bus between three masters: CPU (index 0), Accelerator DMA (index 1) and Debug port (index 2).
- Issues one-hot registered grants and the address-phase and data-phase master indices.
- These indices steer the master-to-slave address/write-data muxes and the slave-response return path.
- Round-robin fairness, locked-sequence protection, bounded bus tenure and parking on a default master.

Parameters:
DEFAULT_MASTER, 0, master index parked on the bus when no request is pending (0..2)
MAX_HOLD, 16, max transfers an owner may issue while others wait before forced re-arbitration; 0 disables the limit
HOLD_W, 5, width of tenure counter; must hold MAX_HOLD

Ports:
in_HCLK  input  1  bus clock, all logic on rising edge
in_HRESETn  input  1  synchronous active-low reset
in_HBUSREQ_CPU  input  1  CPU bus request
in_HBUSREQ_Accelerator  input  1  Accelerator bus request
in_HBUSREQ_Debug  input  1  Debug bus request
in_HLOCK_CPU  input  1  CPU locked-transfer request
in_HLOCK_Accelerator  input  1  Accelerator locked-transfer request
in_HLOCK_Debug  input  1  Debug locked-transfer request
in_HTRANS  input  2  muxed HTRANS of current address-phase owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
in_HREADY  input  1  muxed bus HREADY
out_HGRANT_CPU  output  1  grant to CPU
out_HGRANT_Accelerator  output  1  grant to Accelerator
out_HGRANT_Debug  output  1  grant to Debug
out_HMASTER  output  2  address-phase owner index
out_HMASTER_data  output  2  data-phase owner index
out_HMASTLOCK  output  1  current address phase is part of a locked sequence

Behaviour:
- Reset: in_HRESETn sampled low at a rising edge of in_HCLK; asynchronous assertion has no effect. Outputs are set as follows:
  - grant one-hot = DEFAULT_MASTER, all other grants 0.
  - out_HMASTER = out_HMASTER_data = DEFAULT_MASTER; out_HMASTLOCK = 0.
  - State PARK; tenure counter 0; round-robin pointer = DEFAULT_MASTER.
- Reset mid-transfer or mid-lock: state is abandoned immediately and the next cycle matches the reset values.
- Clocked terms:
  - xfer = in_HREADY & in_HTRANS[1] (NONSEQ or SEQ accepted).
  - arb_pt = in_HREADY & state != LOCKED.
- Grant update happens only at arb_pt; grants stay one-hot at all times and never change while in_HREADY = 0.
- Winner search is round-robin over requesting masters, order owner+1, owner+2, owner (mod 3).
  - The owner keeps the bus only if it still requests and its tenure has not expired.
  - An expired owner competes last.
- States:
  - PARK: no request pending; grant = DEFAULT_MASTER. At arb_pt with any request -> GRANTED to the winner; counter cleared.
  - GRANTED: owner holds grant; counter increments on each xfer, saturating at MAX_HOLD.
    - At arb_pt, if the owner's in_HLOCK_x = 1 and in_HTRANS = NONSEQ -> LOCKED, grant held, counter held.
    - Else if the owner's request dropped, or (MAX_HOLD != 0 & counter == MAX_HOLD & another request pending), re-arbitrate: winner -> GRANTED with counter cleared; no requester -> PARK.
    - Otherwise stay in GRANTED.
  - LOCKED: grant frozen regardless of other requests or tenure. Exit to GRANTED at an edge with in_HREADY = 1 and the owner's in_HLOCK_x = 0; counter cleared. Re-arbitration is evaluated on the following edge.
- out_HMASTER <= index of asserted grant on every edge with in_HREADY = 1; otherwise held.
- out_HMASTER_data <= out_HMASTER on every edge with in_HREADY = 1; otherwise held.
- out_HMASTLOCK <= (state LOCKED or entering LOCKED) on in_HREADY = 1 edges; otherwise held.
- Latency, with HREADY = 1 throughout:
  - request at edge n -> grant visible after edge n.
  - out_HMASTER follows after edge n+1.
  - out_HMASTER_data follows after edge n+2.
- Simultaneous requests from all masters rotate C->A->D->C starting after the current pointer.
- Wait states (in_HREADY = 0) stall grant, counter, HMASTER and HMASTER_data completely.
- BUSY and IDLE transfers do not increment the counter.

Test Plan:
- Reset with in_HRESETn = 0 for 2 cycles, DEFAULT_MASTER = 0 -> out_HGRANT_CPU = 1, others 0, out_HMASTER = out_HMASTER_data = 0, out_HMASTLOCK = 0; asynchronous low pulse between edges -> no change.
- Accelerator request only, HREADY = 1 -> out_HGRANT_Accelerator = 1 after 1 edge, out_HMASTER = 1 after 2 edges, out_HMASTER_data = 1 after 3 edges; drop request -> re-parks on CPU.
- All three requests held, continuous SEQ, MAX_HOLD = 4 -> grant rotates CPU->Accelerator->Debug->CPU, each owner holding exactly 4 transfers.
- Debug asserts in_HLOCK_Debug with NONSEQ, then CPU requests, tenure expires -> Debug grant held and out_HMASTLOCK = 1 until in_HLOCK_Debug = 0 with HREADY = 1; then CPU is granted.
- Grant change pending while in_HREADY = 0 for 3 cycles -> grants, out_HMASTER and counter frozen; grant changes on the first HREADY = 1 edge.
- Assert reset while in LOCKED with Accelerator owning -> next cycle reset values, state PARK, out_HMASTLOCK = 0.
